// File: rtl/irq_priority_arbiter.sv
// Fixed-priority interrupt arbiter: registers req, accumulates pending events and offers the highest
// eligible index through a valid/ready port. Define IRQ_EDGE_DETECT_EN for rising-edge capture with overflow.
module irq_priority_arbiter #(
  parameter int N_REQ = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic             out_valid,
  output logic [2:0]       out_idx,
  output logic [N_REQ-1:0] pending,
  output logic             ovf
);

  // Handshake: an index transfers on any rising edge where out_valid and out_ready are both 1.
  // Once out_valid rises, out_idx holds until that transfer, whatever req or mask do meanwhile.

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] cap;
  logic [N_REQ-1:0] clr_vec;
  logic [N_REQ-1:0] elig;
  logic             accept;
  logic             ovf_set;

  function automatic logic [2:0] top_idx(input logic [N_REQ-1:0] v);
    top_idx = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) top_idx = i[2:0];
    end
  endfunction

  assign accept  = out_valid & out_ready;
  assign clr_vec = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << out_idx) : '0;
  // The line being accepted this edge must not be offered again on the same edge.
  assign elig    = pending & mask & ~clr_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req;
    end
  end

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_REQ-1:0] req_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_h <= '0;
    end else begin
      req_h <= req_q;
    end
  end

  assign cap     = req_q & ~req_h;
  // A fresh event landing on a still-pending line that is not leaving this edge is lost.
  assign ovf_set = |(cap & pending & ~clr_vec);
`else
  assign cap     = req_q;
  assign ovf_set = 1'b0;
`endif

  // Set wins over clear when a new event hits the line being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            state     <= OFFER;
            out_valid <= 1'b1;
            out_idx   <= top_idx(elig);
          end
        end
        OFFER: begin
          if (accept) begin
            if (|elig) begin
              out_idx <= top_idx(elig);
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Bench for irq_priority_arbiter: directed scenarios plus random traffic, all outputs scored every cycle
// against a behavioural model; mode follows IRQ_EDGE_DETECT_EN.
module tb_irq_priority_arbiter;

`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE_MODE = 1'b1;
`else
  localparam bit EDGE_MODE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask;
  logic       out_ready;
  logic       ovf_clr;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // {valid, idx[2:0], pending[7:0], ovf}
  logic [12:0] exp_q[$];

  irq_priority_arbiter #(.N_REQ(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .out_ready (out_ready),
    .ovf_clr   (ovf_clr),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lines as bit arrays, priority found by scanning from 7 down.
  bit m_rq[8];
  bit m_hist[8];
  bit m_pend[8];
  bit m_valid;
  bit m_ovf;
  int m_idx;

  task automatic model_step();
    bit         ev;
    bit         acc;
    bit         gone;
    bit         lost;
    int         cand;
    logic [7:0] pv;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_rq[i] = 0; m_hist[i] = 0; m_pend[i] = 0;
      end
      m_valid = 0; m_ovf = 0; m_idx = 0;
    end else begin
      acc  = m_valid && out_ready;
      cand = -1;
      for (int i = 7; i >= 0; i--) begin
        if (cand < 0 && m_pend[i] && mask[i] && !(acc && m_idx == i)) cand = i;
      end
      lost = 0;
      for (int i = 0; i < 8; i++) begin
        ev   = EDGE_MODE ? (m_rq[i] && !m_hist[i]) : m_rq[i];
        gone = acc && (m_idx == i);
        if (ev) begin
          if (EDGE_MODE && m_pend[i] && !gone) lost = 1;
          m_pend[i] = 1;
        end else if (gone) begin
          m_pend[i] = 0;
        end
      end
      if (lost) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (!m_valid || acc) begin
        if (cand >= 0) begin
          m_valid = 1; m_idx = cand;
        end else begin
          m_valid = 0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        m_hist[i] = m_rq[i];
        m_rq[i]   = req[i];
      end
    end
    for (int i = 0; i < 8; i++) pv[i] = m_pend[i];
    exp_q.push_back({m_valid, 3'(m_idx), pv, m_ovf});
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // scoreboard monitor
  initial forever begin
    logic [12:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_out_valid", 8'(out_valid), 8'(e[12]));
      if (e[12]) check("sb_out_idx", 8'(out_idx), 8'(e[11:9]));
      check("sb_pending", pending, e[8:1]);
      check("sb_ovf", 8'(ovf), 8'(e[0]));
    end
  end

  // driver tasks
  task automatic pulse(input logic [7:0] v);
    @(negedge clk); req = v;
    @(negedge clk); req = 8'h00;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #2 rst_n = 1'b0;
    cycles(n);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; mask = 8'hFF; out_ready = 1'b0; ovf_clr = 1'b0;
    cycles(3);
    check("reset_valid", 8'(out_valid), 8'h00);
    check("reset_pending", pending, 8'h00);
    #2 rst_n = 1'b1;

    // single request, two-edge latency, one-cycle offer
    out_ready = 1'b1;
    pulse(8'b0000_1000);
    cycles(1);
    check("single_early_valid", 8'(out_valid), 8'h00);
    check("single_pending", pending, 8'h08);
    cycles(1);
    check("single_valid", 8'(out_valid), 8'h01);
    check("single_idx", 8'(out_idx), 8'h03);
    cycles(1);
    check("single_done_valid", 8'(out_valid), 8'h00);
    check("single_done_pending", pending, 8'h00);

    // priority plus stall
    out_ready = 1'b0;
    pulse(8'b1000_0001);
    cycles(2);
    for (int s = 0; s < 5; s++) begin
      check("stall_valid", 8'(out_valid), 8'h01);
      check("stall_idx", 8'(out_idx), 8'h07);
      if (s < 4) cycles(1);
    end
    out_ready = 1'b1;
    cycles(1);
    check("stall_next_idx", 8'(out_idx), 8'h00);
    check("stall_next_valid", 8'(out_valid), 8'h01);
    cycles(1);
    check("stall_end_valid", 8'(out_valid), 8'h00);

    // late higher priority does not preempt an offer
    out_ready = 1'b0;
    pulse(8'h04);
    cycles(2);
    check("late_first_idx", 8'(out_idx), 8'h02);
    pulse(8'h40);
    cycles(2);
    check("late_hold_idx", 8'(out_idx), 8'h02);
    check("late_hold_pending", pending, 8'h44);
    out_ready = 1'b1;
    cycles(1);
    check("late_next_valid", 8'(out_valid), 8'h01);
    check("late_next_idx", 8'(out_idx), 8'h06);
    cycles(2);

    // masking
    mask = 8'hEF;
    pulse(8'h10);
    cycles(3);
    check("mask_valid", 8'(out_valid), 8'h00);
    check("mask_pending", pending, 8'h10);
    mask = 8'hFF;
    cycles(1);
    check("unmask_valid", 8'(out_valid), 8'h01);
    check("unmask_idx", 8'(out_idx), 8'h04);
    cycles(2);

    // overflow on repeated events while stalled
    out_ready = 1'b0;
    pulse(8'h20);
    cycles(2);
    check("ovf_offer_idx", 8'(out_idx), 8'h05);
    pulse(8'h20);
    pulse(8'h20);
    cycles(1);
    check("ovf_set", 8'(ovf), 8'(EDGE_MODE));
    cycles(1);
    check("ovf_sticky", 8'(ovf), 8'(EDGE_MODE));
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 8'(ovf), 8'h00);
    out_ready = 1'b1;
    cycles(4);

    // reset mid-offer with everything pending
    out_ready = 1'b0;
    mask = 8'h00;
    pulse(8'hFF);
    cycles(2);
    check("fill_pending", pending, 8'hFF);
    mask = 8'hFF;
    cycles(1);
    check("fill_idx", 8'(out_idx), 8'h07);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", 8'(out_valid), 8'h00);
    check("async_idx", 8'(out_idx), 8'h00);
    check("async_pending", pending, 8'h00);
    check("async_ovf", 8'(ovf), 8'h00);
    cycles(2);
    #2 rst_n = 1'b1;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      req       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      mask      = ($urandom_range(0, 7) == 0) ? 8'h00 :
                  (($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      ovf_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
    end

    req = 8'h00; mask = 8'hFF; out_ready = 1'b1; ovf_clr = 1'b1;
    cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
